// File: rtl/fma_issue.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fma_issue
// Issue/capture sequencer for an external single-precision fused multiply-add
// unit with a fixed latency. Accepts one operand triple at a time, pulses the
// FMA request, waits out the compute latency, captures result and exception
// flags, presents them on a valid/ready result port, and keeps a sticky OR of
// all captured flags.
//
// Parameters
//   LAT        FMA compute cycles from the req-sampling edge to result
//              visibility. The result is captured LAT+1 edges after that edge.
//
// Ports
//   clk        clock, all state on the rising edge
//   reset      asynchronous active-low reset
//   in_valid   operand handshake valid          in_ready  operand handshake ready
//   in_x/y/z   operands (result = x*y+z)        in_op     negation mode
//   fma_req    one-cycle request to the FMA     fma_x/y/z operands to the FMA
//   fma_rslt   FMA result                       fma_flag  FMA flags {NV,DZ,OF,UF,NX}
//   res_valid  result handshake valid           res_ready result handshake ready
//   res_data   captured result                  res_flag  captured flags
//   flag_clr   synchronous clear of flag_acc    flag_acc  sticky accumulated flags
//   busy       high whenever an operation is in progress
//
// Build option
//   FMA_ISSUE_NEG_EN  when defined, in_op selects sign inversion of x and z:
//                     00 fmadd, 01 fmsub, 10 fnmsub, 11 fnmadd. When undefined,
//                     in_op is ignored and operands pass through unmodified.
// -----------------------------------------------------------------------------
module fma_issue #(
   parameter int LAT = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_x,
   input  logic [31:0] in_y,
   input  logic [31:0] in_z,
   input  logic [1:0]  in_op,
   output logic        fma_req,
   output logic [31:0] fma_x,
   output logic [31:0] fma_y,
   output logic [31:0] fma_z,
   input  logic [31:0] fma_rslt,
   input  logic [4:0]  fma_flag,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic [4:0]  res_flag,
   input  logic        flag_clr,
   output logic [4:0]  flag_acc,
   output logic        busy
);

   localparam int CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      op_x;
   logic [31:0]      op_z;

`ifdef FMA_ISSUE_NEG_EN
   // Raw sign-bit flip; NaN payloads are treated like any other encoding.
   function automatic logic [31:0] flip_sign(input logic [31:0] v, input logic flip);
      return {v[31] ^ flip, v[30:0]};
   endfunction

   assign op_x = flip_sign(in_x, in_op[1]);
   assign op_z = flip_sign(in_z, in_op[0]);
`else
   // in_op has no function in this build.
   logic unused_op;
   assign unused_op = ^in_op;
   assign op_x      = in_x;
   assign op_z      = in_z;
`endif

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         in_ready  <= 1'b0;
         fma_req   <= 1'b0;
         fma_x     <= '0;
         fma_y     <= '0;
         fma_z     <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_flag  <= '0;
         flag_acc  <= '0;
      end else begin
         fma_req <= 1'b0;
         if (flag_clr) flag_acc <= '0;

         case (state)
            IDLE: begin
               // in_ready is registered, so it first rises on the edge after
               // reset release and drops on the accepting edge.
               if (in_valid && in_ready) begin
                  fma_x    <= op_x;
                  fma_y    <= in_y;
                  fma_z    <= op_z;
                  fma_req  <= 1'b1;
                  in_ready <= 1'b0;
                  state    <= ISSUE;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            ISSUE: begin
               // The FMA samples req on this edge; operands stay put until the
               // next accept because the unit reads them late.
               cnt   <= CNT_LOAD;
               state <= WAIT;
            end
            WAIT: begin
               if (cnt == '0) begin
                  res_data  <= fma_rslt;
                  res_flag  <= fma_flag;
                  res_valid <= 1'b1;
                  // A coincident clear drops old flags but keeps the new ones.
                  flag_acc  <= (flag_clr ? 5'd0 : flag_acc) | fma_flag;
                  state     <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fma_issue.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fma_issue
// Scoreboard bench for fma_issue. A behavioural FMA stub answers requests with
// the configured latency (result visible for exactly one cycle, operands read
// late); expected results are computed from the accepted inputs and queued,
// and a monitor pops and compares whenever a new result is presented.
// -----------------------------------------------------------------------------
module tb_fma_issue;
   localparam int LAT = 6;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  flag;
      int          edge_n;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_x = '0, in_y = '0, in_z = '0;
   logic [1:0]  in_op = '0;
   logic        fma_req;
   logic [31:0] fma_x, fma_y, fma_z;
   logic [31:0] fma_rslt = '0;
   logic [4:0]  fma_flag = '0;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic [31:0] res_data;
   logic [4:0]  res_flag;
   logic        flag_clr = 1'b0;
   logic [4:0]  flag_acc;
   logic        busy;

   int   checks = 0, errors = 0, cyc = 0, req_cnt = 0, acc_cnt = 0;
   bit   rnd_mode = 1'b0;
   exp_t q[$];

   fma_issue #(.LAT(LAT)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_op(in_op),
      .fma_req(fma_req), .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z),
      .fma_rslt(fma_rslt), .fma_flag(fma_flag),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_flag(res_flag),
      .flag_clr(flag_clr), .flag_acc(flag_acc), .busy(busy)
   );

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc = cyc + 1; end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference arithmetic ----------------
   function automatic bit is_nan(input logic [31:0] s);
      return (s[30:23] == 8'hFF) && (s[22:0] != 23'd0);
   endfunction

   function automatic logic [63:0] s2d(input logic [31:0] s);
      logic [7:0] e;
      e = s[30:23];
      if (e == 8'hFF) return {s[31], 11'h7FF, s[22:0], 29'd0};
      if (e == 8'h00) return {s[31], 63'd0};  // subnormal operands flushed
      return {s[31], 11'(e) + 11'd896, s[22:0], 29'd0};
   endfunction

   // Returns {result[31:0], flags[4:0]} for x*y+z, flags {NV,DZ,OF,UF,NX}.
   function automatic logic [36:0] fma_ref(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      logic [63:0] d;
      logic [10:0] ex;
      logic [51:0] mt;
      logic [31:0] mag;
      int          e;
      logic        nx;
      if (is_nan(x) || is_nan(y) || is_nan(z)) begin
         if ((is_nan(x) && !x[22]) || (is_nan(y) && !y[22]) || (is_nan(z) && !z[22]))
            return {32'hFFC00000, 5'b10000};
         return {32'hFFC00000, 5'b00000};
      end
      d  = $realtobits($bitstoreal(s2d(x)) * $bitstoreal(s2d(y)) + $bitstoreal(s2d(z)));
      ex = d[62:52];
      mt = d[51:0];
      if (ex == 11'h7FF) begin
         if (mt != 52'd0) return {32'hFFC00000, 5'b10000};
         return {d[63], 8'hFF, 23'd0, 5'b00000};
      end
      if (ex == 11'd0) return {d[63], 31'd0, (mt != 52'd0) ? 5'b00011 : 5'b00000};
      e = int'(ex) - 896;
      if (e >= 255) return {d[63], 8'hFF, 23'd0, 5'b00101};
      if (e <= 0)   return {d[63], 31'd0, 5'b00011};
      nx  = (mt[28:0] != 29'd0);
      mag = {1'b0, e[7:0], mt[51:29]};
      if (mt[28] && ((mt[27:0] != 28'd0) || mt[29])) mag = mag + 32'd1;
      if (mag[30:23] == 8'hFF) return {d[63], 8'hFF, 23'd0, 5'b00101};
      return {d[63], mag[30:0], 4'b0000, nx};
   endfunction

   // Operands as the FMA should see them for a given in_op.
   function automatic logic [95:0] apply_op(input logic [31:0] x, input logic [31:0] y,
                                            input logic [31:0] z, input logic [1:0] op);
`ifdef FMA_ISSUE_NEG_EN
      x[31] = x[31] ^ op[1];
      z[31] = z[31] ^ op[0];
`else
      if (op == 2'b11) x = x;  // negation mode has no effect in this build
`endif
      return {x, y, z};
   endfunction

   function automatic logic [31:0] rnd_fp();
      case ($urandom_range(0, 15))
         0: return 32'h00000000;
         1: return 32'h7F800000;
         2: return 32'hFF800000;
         3: return 32'h7FC00000;
         4: return 32'h7F800001;
         5: return 32'h3F800000;
         default: return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 145)), 23'($urandom)};
      endcase
   endfunction

   // ---------------- FMA unit stub ----------------
   int          rem = -1;
   logic [36:0] stub_rf;
   initial forever begin
      @(negedge clk);
      fma_rslt = $urandom;
      fma_flag = 5'($urandom);
      if (rem > 0) rem--;
      if (rem == 0) begin
         stub_rf  = fma_ref(fma_x, fma_y, fma_z);
         fma_rslt = stub_rf[36:5];
         fma_flag = stub_rf[4:0];
         rem      = -1;
      end
      if (fma_req) begin
         req_cnt++;
         rem = LAT + 1;
      end
   end

   // ---------------- background random handshake / clear ----------------
   initial forever begin
      @(posedge clk); #1;
      if (rnd_mode) begin
         res_ready = 1'($urandom_range(0, 1));
         flag_clr  = ($urandom_range(0, 5) == 0);
      end
   end

   // ---------------- monitor ----------------
   logic        mon_prev_vld = 1'b0, mon_prev_clr = 1'b0;
   logic [4:0]  acc_model = '0, cur_flag = '0;
   logic [31:0] cur_data = '0;
   exp_t        mon_e;
   initial forever begin
      @(negedge clk);
      if (!reset) begin
         mon_prev_vld = 1'b0;
         mon_prev_clr = 1'b0;
         acc_model    = '0;
      end else begin
         if (res_valid && !mon_prev_vld) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_result: got res_data %h, required no result", res_data);
            end else begin
               mon_e = q.pop_front();
               chk("res_data", 64'(res_data), 64'(mon_e.data));
               chk("res_flag", 64'(res_flag), 64'(mon_e.flag));
               chk("capture_edge", 64'(cyc - mon_e.edge_n), 64'(LAT + 2));
               cur_data = mon_e.data;
               cur_flag = mon_e.flag;
            end
            acc_model = (mon_prev_clr ? 5'd0 : acc_model) | cur_flag;
         end else begin
            if (mon_prev_clr) acc_model = '0;
            if (res_valid) begin
               chk("res_data_hold", 64'(res_data), 64'(cur_data));
               chk("res_flag_hold", 64'(res_flag), 64'(cur_flag));
            end
         end
         chk("flag_acc", 64'(flag_acc), 64'(acc_model));
         if (in_ready)  chk("ready_only_idle", 64'(busy), 64'(1'b0));
         if (res_valid) chk("valid_busy", 64'(busy), 64'(1'b1));
         if (fma_req)   chk("req_busy", 64'(busy), 64'(1'b1));
         mon_prev_vld = res_valid;
         mon_prev_clr = flag_clr;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z, input logic [1:0] op);
      exp_t        e;
      logic [95:0] p;
      logic [36:0] rf;
      bit          ok;
      ok = 1'b0;
      in_valid = 1'b1; in_x = x; in_y = y; in_z = z; in_op = op;
      for (int i = 0; i < 200; i++) begin
         if (in_ready) begin ok = 1'b1; break; end
         tick();
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 200 cycles");
         in_valid = 1'b0;
         return;
      end
      p  = apply_op(x, y, z, op);
      rf = fma_ref(p[95:64], p[63:32], p[31:0]);
      e.data = rf[36:5]; e.flag = rf[4:0]; e.edge_n = cyc + 1;
      q.push_back(e);
      acc_cnt++;
      tick();
      in_valid = 1'b0; in_x = $urandom; in_y = $urandom; in_z = $urandom; in_op = 2'($urandom_range(0, 3));
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300; i++) begin
         if (q.size() == 0 && in_ready) return;
         tick();
      end
      checks++; errors++;
      $display("FAIL idle_timeout: outstanding %0d, in_ready %0d, required 0 and 1", q.size(), in_ready);
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 100; i++) begin
         if (res_valid) return;
         tick();
      end
      checks++; errors++;
      $display("FAIL valid_timeout: res_valid stayed 0, required 1");
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_in_ready"},  64'(in_ready),  64'(0));
      chk({tag, "_busy"},      64'(busy),      64'(0));
      chk({tag, "_fma_req"},   64'(fma_req),   64'(0));
      chk({tag, "_fma_x"},     64'(fma_x),     64'(0));
      chk({tag, "_fma_y"},     64'(fma_y),     64'(0));
      chk({tag, "_fma_z"},     64'(fma_z),     64'(0));
      chk({tag, "_res_valid"}, 64'(res_valid), 64'(0));
      chk({tag, "_res_data"},  64'(res_data),  64'(0));
      chk({tag, "_res_flag"},  64'(res_flag),  64'(0));
      chk({tag, "_flag_acc"},  64'(flag_acc),  64'(0));
   endtask

   logic [31:0] held;

   initial begin
      reset = 1'b0;
      repeat (3) tick();
      chk_all_zero("reset");
      reset = 1'b1;
      #1;
      chk("in_ready_before_edge", 64'(in_ready), 64'(0));
      tick();
      chk("in_ready_after_reset", 64'(in_ready), 64'(1));

      // 1*2+3
      send(32'h3F800000, 32'h40000000, 32'h40400000, 2'b00);
      wait_idle();
      chk("basic_data", 64'(res_data), 64'(32'h40A00000));
      chk("basic_flag", 64'(res_flag), 64'(0));

`ifdef FMA_ISSUE_NEG_EN
      send(32'h40000000, 32'h40400000, 32'h3F800000, 2'b01);
      wait_idle();
      chk("fmsub_data", 64'(res_data), 64'(32'h40A00000));
      send(32'h40000000, 32'h40400000, 32'h3F800000, 2'b11);
      wait_idle();
      chk("fnmadd_data", 64'(res_data), 64'(32'hC0E00000));
`endif

      // inf*0+1: invalid, sticky NV until cleared
      flag_clr = 1'b1; tick(); flag_clr = 1'b0;
      send(32'h7F800000, 32'h00000000, 32'h3F800000, 2'b00);
      wait_idle();
      chk("nv_data", 64'(res_data), 64'(32'hFFC00000));
      chk("nv_flag", 64'(res_flag), 64'(5'b10000));
      chk("nv_acc", 64'(flag_acc), 64'(5'b10000));
      repeat (3) begin tick(); chk("nv_acc_sticky", 64'(flag_acc), 64'(5'b10000)); end
      flag_clr = 1'b1; tick(); flag_clr = 1'b0;
      chk("nv_acc_cleared", 64'(flag_acc), 64'(0));

      // result held while res_ready is low
      res_ready = 1'b0;
      send(32'h40000000, 32'h40400000, 32'h3F800000, 2'b00);
      wait_valid();
      held = res_data;
      repeat (5) begin
         chk("stall_valid", 64'(res_valid), 64'(1));
         chk("stall_in_ready", 64'(in_ready), 64'(0));
         chk("stall_no_req", 64'(fma_req), 64'(0));
         chk("stall_data", 64'(res_data), 64'(held));
         tick();
      end
      res_ready = 1'b1;
      tick();
      chk("stall_release_valid", 64'(res_valid), 64'(0));
      chk("stall_release_ready", 64'(in_ready), 64'(1));

      // clear coincident with capture of an inexact result
      send(32'h7F800000, 32'h00000000, 32'h00000000, 2'b00);
      wait_idle();
      send(32'h3F800001, 32'h3F800001, 32'h00000000, 2'b00);
      repeat (LAT + 1) tick();
      flag_clr = 1'b1; tick(); flag_clr = 1'b0;
      wait_idle();
      chk("clr_capture_flag", 64'(res_flag), 64'(5'b00001));
      chk("clr_capture_acc", 64'(flag_acc), 64'(5'b00001));

      // reset three cycles into WAIT abandons the operation
      send(32'h3F800001, 32'h40000000, 32'h3F800000, 2'b00);
      repeat (3) tick();
      chk("abort_pre_busy", 64'(busy), 64'(1));
      reset = 1'b0;
      #1;
      chk_all_zero("abort");
      q.delete();
      repeat (3) tick();
      reset = 1'b1;
      repeat (20) tick();
      chk("abort_no_valid", 64'(res_valid), 64'(0));
      chk("abort_ready", 64'(in_ready), 64'(1));
      send(32'h40000000, 32'h40400000, 32'h3F800000, 2'b00);
      wait_idle();
      chk("after_abort_data", 64'(res_data), 64'(32'h40E00000));

      // randomized traffic
      rnd_mode = 1'b1;
      for (int n = 0; n < 60; n++) begin
         repeat ($urandom_range(0, 3)) tick();
         if (!in_ready && ($urandom_range(0, 1) == 1)) begin
            in_valid = 1'b1; in_x = $urandom; in_y = $urandom; in_z = $urandom;
            tick();
            in_valid = 1'b0;
         end
         send(rnd_fp(), rnd_fp(), rnd_fp(), 2'($urandom_range(0, 3)));
      end
      rnd_mode = 1'b0;
      tick();
      res_ready = 1'b1;
      flag_clr  = 1'b0;
      wait_idle();
      repeat (3) tick();

      chk("req_per_accept", 64'(req_cnt), 64'(acc_cnt));
      chk("scoreboard_drained", 64'(q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, required completion before 2 ms");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fma_issue.md
FMA_ISSUE -- requirements
Module: fma_issue

Interface
REQ-001 SHALL have parameter LAT, default 6, giving FMA compute cycles from the req-sampling edge to result visibility.
REQ-002 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports in_valid input 1 and in_ready output 1: operand handshake.
REQ-005 SHALL have ports in_x, in_y, in_z input 32 each: IEEE-754 single operands, result = x*y+z.
REQ-006 SHALL have port in_op input 2: negation mode, used only under FMA_ISSUE_NEG_EN.
REQ-007 SHALL have ports fma_req output 1, fma_x, fma_y, fma_z output 32 each: drive the FMA unit's req, x, y and z inputs.
REQ-008 SHALL have ports fma_rslt input 32 and fma_flag input 5: FMA result and flags {NV,DZ,OF,UF,NX}.
REQ-009 SHALL have ports res_valid output 1, res_ready input 1, res_data output 32, res_flag output 5: result handshake.
REQ-010 SHALL have ports flag_clr input 1 and flag_acc output 5: sticky accumulated flags.
REQ-011 SHALL have port busy output 1: high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT and DONE.
REQ-013 SHALL assert in_ready only in IDLE.
REQ-014 SHALL, on in_valid&in_ready, register the operands into fma_x/y/z and go to ISSUE.
REQ-015 SHALL hold fma_x/y/z constant from ISSUE until the next accept, because the FMA reads its operands during late cycles.
REQ-016 SHALL drive fma_req high for exactly one cycle, in ISSUE, and then go to WAIT with a down-counter loaded with LAT.
REQ-017 SHALL decrement the counter in WAIT.
REQ-018 SHALL, on the edge after the counter reaches 0, capture fma_rslt into res_data and fma_flag into res_flag, and go to DONE.
REQ-019 SHALL place the capture at edge LAT+1 after the req-sampling edge, so the default capture is at edge 7.
REQ-020 SHALL assert res_valid only in DONE, with res_data and res_flag stable while res_ready is low.
REQ-021 SHALL, on res_valid&res_ready, go to IDLE.
REQ-022 SHALL make a new accept possible no earlier than the cycle after DONE exits (no overlap, one operation in flight).
REQ-023 SHALL, on the capture edge, update flag_acc <= flag_acc | fma_flag.
REQ-024 SHALL make flag_clr synchronous; flag_clr coincident with a capture yields flag_acc = fma_flag (capture wins over clear).
REQ-025 SHALL treat an in_valid that deasserts before acceptance as a no-op.
REQ-026 SHALL ignore in_* outside IDLE.
REQ-027 SHALL, for LAT=0, capture on the edge following WAIT entry.

Reset
REQ-028 SHALL, with reset low, force state IDLE, counter 0, fma_req 0, fma_x/y/z 0, res_valid 0, res_data 0, res_flag 0, flag_acc 0, busy 0 and in_ready 0, asynchronously.
REQ-029 SHALL assert in_ready 1 from the first clock edge after reset deasserts.
REQ-030 SHALL, on reset asserted mid-operation (ISSUE/WAIT/DONE), abandon the operation: no res_valid, and the pending result is discarded.

Configuration
REQ-031 SHALL, with FMA_ISSUE_NEG_EN defined, register in_x sign inverted when in_op[1]=1 and in_z sign inverted when in_op[0]=1.
REQ-032 SHALL treat in_op as: 00 fmadd, 01 fmsub, 10 fnmsub, 11 fnmadd.
REQ-033 SHALL apply this inversion as a raw bit-31 flip for all encodings, including NaN.
REQ-034 SHALL, without FMA_ISSUE_NEG_EN, ignore in_op and pass operands unmodified.

Verification
REQ-035 SHALL cover: x=3F800000, y=40000000, z=40400000, op=00 -> res_data=40A00000, res_flag=00000, res_valid at edge 8 after accept (default LAT).
REQ-036 SHALL cover, with FMA_ISSUE_NEG_EN: x=40000000, y=40400000, z=3F800000, op=01 -> res_data=40A00000; op=11 -> C0E00000.
REQ-037 SHALL cover: x=7F800000, y=00000000, z=3F800000 -> res_data=FFC00000, res_flag=10000, flag_acc=10000 held until a flag_clr pulse, then 00000.
REQ-038 SHALL cover: res_ready low for 5 cycles in DONE -> res_valid and res_data stable, in_ready 0, fma_req not reasserted; handshake completes, then in_ready=1 next cycle.
REQ-039 SHALL cover: reset pulsed low 3 cycles into WAIT -> all outputs 0 immediately, no res_valid afterwards, next operation completes correctly.
REQ-040 SHALL cover: flag_clr asserted on the capture edge of an NX-raising op -> flag_acc=00001.
